// File: rtl/warn_door_multi_if.sv
// Door-warning bus: raw sensors and acks in, debounced status and warnings out.
// The master side drives sensors/acks; the slave side is the warning block.
interface warn_door_multi_if #(
    parameter int NUM_DOORS = 4
);
    logic [NUM_DOORS-1:0] door_open;
    logic [NUM_DOORS-1:0] ack;
    logic [NUM_DOORS-1:0] door_state;
    logic [NUM_DOORS-1:0] warn_door_open;
    logic                 any_warn;
    logic                 alarm;

    modport master (
        output door_open, ack,
        input  door_state, warn_door_open, any_warn, alarm
    );

    modport slave (
        input  door_open, ack,
        output door_state, warn_door_open, any_warn, alarm
    );
endinterface

// File: rtl/warn_door_multi.sv
// Multi-door open-too-long warning: per-door debounce + warn/mute FSM,
// plus a shared blinking alarm driven while any door is warning.
module warn_door_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WARN_DELAY      = 16,
    parameter int MUTE_CYCLES     = 32,
    parameter int TW              = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic ack,
    output logic door_state,
    output logic warn,
    output logic warn_nxt
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {CLOSED, OPEN_WAIT, WARN, MUTED} state_t;

    logic [DW-1:0] db_cnt;
    logic [TW-1:0] timer, timer_nxt;
    state_t        state, state_nxt;

    // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt     <= '0;
            door_state <= 1'b0;
        end else if (raw != door_state) begin
            if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                door_state <= raw;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLOSED;
            timer <= '0;
            warn  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            warn  <= warn_nxt;
        end
    end

    // A closed door wins over ack and timer expiry in every state.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            CLOSED: begin
                timer_nxt = '0;
                if (door_state) begin
                    if (WARN_DELAY == 1) begin
                        state_nxt = WARN;
                    end else begin
                        state_nxt = OPEN_WAIT;
                        timer_nxt = TW'(1);
                    end
                end
            end
            OPEN_WAIT: begin
                if (!door_state) begin
                    state_nxt = CLOSED;
                    timer_nxt = '0;
                end else if (timer == TW'(WARN_DELAY - 1)) begin
                    state_nxt = WARN;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            WARN: begin
                if (!door_state) begin
                    state_nxt = CLOSED;
                end else if (ack) begin
                    state_nxt = MUTED;
                    timer_nxt = '0;
                end
            end
            MUTED: begin
                if (!door_state) begin
                    state_nxt = CLOSED;
                    timer_nxt = '0;
                end else if (timer == TW'(MUTE_CYCLES - 1)) begin
                    state_nxt = WARN;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                state_nxt = CLOSED;
                timer_nxt = '0;
            end
        endcase
        warn_nxt = (state_nxt == WARN);
    end
endmodule

module warn_door_multi #(
    parameter int NUM_DOORS       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WARN_DELAY      = 16,
    parameter int MUTE_CYCLES     = 32,
    parameter int BLINK_HALF      = 2
) (
    input  logic             clock,
    input  logic             reset,
    warn_door_multi_if.slave bus
);
    localparam int TMAX = (WARN_DELAY > MUTE_CYCLES) ? WARN_DELAY : MUTE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(BLINK_HALF + 1);

    logic [NUM_DOORS-1:0] warn_nxt;
    logic                 any_warn_q, alarm_q;
    logic [BW-1:0]        blink_cnt;

    for (genvar g = 0; g < NUM_DOORS; g++) begin : g_chan
        warn_door_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .WARN_DELAY     (WARN_DELAY),
            .MUTE_CYCLES    (MUTE_CYCLES),
            .TW             (TW)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .raw       (bus.door_open[g]),
            .ack       (bus.ack[g]),
            .door_state(bus.door_state[g]),
            .warn      (bus.warn_door_open[g]),
            .warn_nxt  (warn_nxt[g])
        );
    end

    // any_warn uses the channels' next-state so it lands on the same edge as warn_door_open.
    always_ff @(posedge clock) begin
        if (reset) begin
            any_warn_q <= 1'b0;
            alarm_q    <= 1'b0;
            blink_cnt  <= '0;
        end else begin
            any_warn_q <= |warn_nxt;
            if (!(|warn_nxt)) begin
                alarm_q   <= 1'b0;
                blink_cnt <= '0;
            end else if (!any_warn_q) begin
                alarm_q   <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                alarm_q   <= ~alarm_q;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign bus.any_warn = any_warn_q;
    assign bus.alarm    = alarm_q;
endmodule

// File: tb/tb_warn_door_multi.sv
// Bench for warn_door_multi: directed scenarios then random traffic, every
// cycle compared against a timestamp-based reference model.
module tb_warn_door_multi;
    localparam int N = 4, D = 4, W = 16, M = 32, B = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    warn_door_multi_if #(.NUM_DOORS(N)) bus ();

    warn_door_multi #(
        .NUM_DOORS(N), .DEBOUNCE_CYCLES(D), .WARN_DELAY(W),
        .MUTE_CYCLES(M), .BLINK_HALF(B)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model state
    int                   t;
    logic [N-1:0][D-1:0]  hist;
    logic [N-1:0]         m_ds, m_warn;
    int                   open_e [N];
    int                   mute_e [N];
    bit                   muted  [N];
    logic                 m_aw, m_alarm;
    int                   k;
    int                   n_chk = 0, n_pass = 0;

    task automatic model_edge(input logic r, input logic [N-1:0] dop, input logic [N-1:0] ak);
        logic [N-1:0] wn;
        logic         aw_old;
        t++;
        if (r) begin
            hist = '0; m_ds = '0; m_warn = '0; m_aw = 1'b0; m_alarm = 1'b0; k = 0;
            for (int i = 0; i < N; i++) begin
                open_e[i] = -1; mute_e[i] = 0; muted[i] = 1'b0;
            end
            return;
        end
        wn = '0;
        for (int i = 0; i < N; i++) begin
            // The warning logic sees the debounced value from before this edge.
            if (!m_ds[i]) begin
                open_e[i] = -1;
                muted[i]  = 1'b0;
            end else begin
                if (open_e[i] < 0) open_e[i] = t;
                if (muted[i]) begin
                    if (t - mute_e[i] >= M) begin
                        muted[i] = 1'b0;
                        wn[i]    = 1'b1;
                    end
                end else if (m_warn[i] && ak[i]) begin
                    muted[i]  = 1'b1;
                    mute_e[i] = t;
                end else begin
                    wn[i] = (t - open_e[i] >= W - 1);
                end
            end
            hist[i] = {hist[i][D-2:0], dop[i]};
            if (hist[i] == {D{~m_ds[i]}}) m_ds[i] = ~m_ds[i];
        end
        m_warn = wn;
        aw_old = m_aw;
        m_aw   = |wn;
        if (!m_aw) begin
            m_alarm = 1'b0; k = 0;
        end else if (!aw_old) begin
            m_alarm = 1'b1; k = 0;
        end else begin
            k++;
            m_alarm = ((k / B) % 2) == 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic tick(input logic r, input logic [N-1:0] dop, input logic [N-1:0] ak);
        reset         = r;
        bus.door_open = dop;
        bus.ack       = ak;
        @(posedge clock);
        model_edge(r, dop, ak);
        #1;
        check("door_state", 32'(bus.door_state), 32'(m_ds));
        check("warn_door_open", 32'(bus.warn_door_open), 32'(m_warn));
        check("any_warn", 32'(bus.any_warn), 32'(m_aw));
        check("alarm", 32'(bus.alarm), 32'(m_alarm));
    endtask

    initial begin
        logic [N-1:0] rd, ra;
        t = 0;
        bus.door_open = '0;
        bus.ack       = '0;

        // Long reset with doors closed, then idle
        repeat (30) tick(1'b1, 4'b0000, 4'b0000);
        check("reset_warn", 32'(bus.warn_door_open), 32'h0);
        repeat (5) tick(1'b0, 4'b0000, 4'b0000);

        // Door 0 held open: warning exactly on edge D+W
        repeat (19) tick(1'b0, 4'b0001, 4'b0000);
        check("d0_edge19", 32'(bus.warn_door_open), 32'h0);
        tick(1'b0, 4'b0001, 4'b0000);
        check("d0_edge20", 32'(bus.warn_door_open), 32'h1);
        repeat (12) tick(1'b0, 4'b0001, 4'b0000);
        repeat (4) tick(1'b0, 4'b0000, 4'b0000);
        check("d0_close4", 32'(bus.warn_door_open), 32'h1);
        tick(1'b0, 4'b0000, 4'b0000);
        check("d0_close5", 32'(bus.warn_door_open), 32'h0);
        check("d0_alarm_off", 32'(bus.alarm), 32'h0);
        repeat (3) tick(1'b0, 4'b0000, 4'b0000);

        // Door 1 glitches shorter than the debounce window
        repeat (8) begin
            repeat (3) tick(1'b0, 4'b0010, 4'b0000);
            repeat (3) tick(1'b0, 4'b0000, 4'b0000);
        end
        check("d1_glitch", 32'(bus.door_state[1]), 32'h0);

        // Door 2: ack mutes for M cycles, then re-warn; then ack coincides with close
        repeat (20) tick(1'b0, 4'b0100, 4'b0000);
        tick(1'b0, 4'b0100, 4'b0100);
        repeat (31) tick(1'b0, 4'b0100, 4'b0000);
        check("d2_muted", 32'(bus.warn_door_open[2]), 32'h0);
        tick(1'b0, 4'b0100, 4'b0000);
        check("d2_rewarn", 32'(bus.warn_door_open[2]), 32'h1);
        repeat (4) tick(1'b0, 4'b0000, 4'b0000);
        tick(1'b0, 4'b0000, 4'b0100);
        repeat (40) tick(1'b0, 4'b0000, 4'b0000);
        check("d2_closed", 32'(bus.warn_door_open[2]), 32'h0);

        // Doors 0 and 3 five cycles apart; door 0 closes while door 3 keeps warning
        repeat (5) tick(1'b0, 4'b0001, 4'b0000);
        repeat (30) tick(1'b0, 4'b1001, 4'b0000);
        repeat (10) tick(1'b0, 4'b1000, 4'b0000);
        check("d3_alone", 32'(bus.any_warn), 32'h1);
        repeat (10) tick(1'b0, 4'b0000, 4'b0000);

        // One-cycle reset mid-WARN with door still open
        repeat (22) tick(1'b0, 4'b0001, 4'b0000);
        tick(1'b1, 4'b0001, 4'b0000);
        check("rst_mid_warn", 32'(bus.warn_door_open), 32'h0);
        repeat (19) tick(1'b0, 4'b0001, 4'b0000);
        check("rst_edge19", 32'(bus.warn_door_open), 32'h0);
        tick(1'b0, 4'b0001, 4'b0000);
        check("rst_edge20", 32'(bus.warn_door_open), 32'h1);

        // Random traffic: slow door changes, sparse acks, rare resets
        rd = '0;
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(29) == 0) rd[i] = ~rd[i];
                ra[i] = ($urandom_range(19) == 0);
            end
            tick($urandom_range(499) == 0, rd, ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/warn_door_multi.md
WARN_DOOR_MULTI -- requirements
Module: warn_door_multi

Interface
REQ-001 Parameter NUM_DOORS, default 4, number of independent door channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive samples needed before a raw change is accepted (>=1).
REQ-003 Parameter WARN_DELAY, default 16, cycles a debounced door must stay open before warning (>=1).
REQ-004 Parameter MUTE_CYCLES, default 32, cycles an acknowledged warning stays silenced (>=1).
REQ-005 Parameter BLINK_HALF, default 2, half-period in cycles of the blinking alarm output (>=1).
REQ-006 clock  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 door_open  input  NUM_DOORS  raw door sensors, bit i = door i open.
REQ-009 ack  input  NUM_DOORS  per-door warning acknowledge, level-sampled each edge.
REQ-010 door_state  output  NUM_DOORS  debounced door status, registered.
REQ-011 warn_door_open  output  NUM_DOORS  per-door warning, high in WARN state only, registered.
REQ-012 any_warn  output  1  OR of warn_door_open, registered in the same cycle as warn_door_open.
REQ-013 alarm  output  1  blinking alarm, toggles every BLINK_HALF cycles while any_warn=1, else 0.

Function
REQ-014 Each channel SHALL debounce independently: door_state[i] takes a new value on the edge at which door_open[i] has been sampled differing from door_state[i] on DEBOUNCE_CYCLES consecutive edges; any matching sample clears the count.
REQ-015 Each channel SHALL run a four-state FSM: CLOSED, OPEN_WAIT, WARN, MUTED, with its own timer wide enough for max(WARN_DELAY, MUTE_CYCLES).
REQ-016 CLOSED: timer=0; door_state[i]=1 -> OPEN_WAIT.
REQ-017 OPEN_WAIT: timer increments; door_state[i]=0 -> CLOSED; timer reaching WARN_DELAY -> WARN.
REQ-018 WARN: warn_door_open[i]=1; door_state[i]=0 -> CLOSED; ack[i]=1 -> MUTED with timer cleared.
REQ-019 MUTED: warn_door_open[i]=0, timer increments; door_state[i]=0 -> CLOSED; timer reaching MUTE_CYCLES -> WARN (re-warn).
REQ-020 Door closing SHALL take priority over ack and over timer expiry in the same cycle.
REQ-021 ack[i] outside WARN SHALL be ignored; holding ack high does not re-mute after re-warn until ack is sampled again in WARN (level, so held ack mutes again on the first WARN cycle).
REQ-022 Latency: with raw door_open[i] held 1, warn_door_open[i] SHALL rise on edge DEBOUNCE_CYCLES+WARN_DELAY, counting the first edge sampling 1 as edge 1.
REQ-023 With raw door_open[i] held 0 from WARN, warn_door_open[i] SHALL fall on edge DEBOUNCE_CYCLES+1 after the first edge sampling 0.
REQ-024 A raw glitch shorter than DEBOUNCE_CYCLES SHALL not change door_state or FSM state.
REQ-025 alarm SHALL be 1 on the first cycle any_warn is 1, toggle every BLINK_HALF cycles while any_warn stays 1, and return to 0 with the blink counter cleared on the cycle any_warn falls.
REQ-026 Channels SHALL not interact except through any_warn and alarm.

Reset
REQ-027 While reset=1 at an edge: all FSMs -> CLOSED, timers and debounce counters -> 0, door_state=0, warn_door_open=0, any_warn=0, alarm=0.
REQ-028 Reset SHALL override all inputs, including mid-WARN or mid-MUTED; after release a door still open restarts from debounce (full REQ-022 latency).

Verification (defaults: D=4, W=16, M=32, B=2)
REQ-029 Reset held 30 cycles, door_open=0 -> all outputs 0 throughout and after release.
REQ-030 door_open[0]=1 held -> warn_door_open=4'b0001 from edge 20, any_warn=1, alarm pattern 1,1,0,0,1,1...; door_open[0]=0 -> warn clears on edge 5 after, alarm 0.
REQ-031 door_open[1] pulses 1 for 3 cycles, repeated every 6 cycles -> door_state[1] stays 0, no warning.
REQ-032 Door 2 in WARN, ack[2]=1 one cycle -> warn_door_open[2]=0 for 32 cycles then re-asserts; ack and door close in same cycle -> CLOSED, no re-warn.
REQ-033 Doors 0 and 3 open 5 cycles apart -> independent warnings 5 cycles apart; closing door 0 leaves any_warn=1 and alarm blinking uninterrupted.
REQ-034 reset=1 for one cycle while door 0 in WARN with door held open -> outputs 0 next cycle, warning returns exactly 20 edges after reset release.
